fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the control unit and register file.
- Owns the PC and issues word-aligned requests to the instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned words in a small FIFO and presents them with their PC to decode through a valid/ready handshake.
- Taken branches/jumps arrive as a redirect (PCSrc plus target) that flushes buffered and in-flight fetches.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests (power of two, ≥2).

Ports:
- clk  in  1  Clock; all state updates on rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- imem_req_valid  out  1  Fetch request valid.
- imem_req_ready  in  1  Memory accepts request this cycle.
- imem_req_addr  out  ADDR_WIDTH  Fetch address; equals the current PC, bits[1:0] always 0.
- imem_rsp_valid  in  1  Response word valid; responses are in request order, latency ≥1 cycle.
- imem_rsp_data  in  DATA_WIDTH  Response instruction word.
- redirect_valid  in  1  Taken branch/jump (PCSrc).
- redirect_pc  in  ADDR_WIDTH  Redirect target.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  Decode consumes head.
- instr  out  DATA_WIDTH  FIFO head instruction.
- instr_pc  out  ADDR_WIDTH  PC of head instruction.

Behaviour:
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Reset state: FSM=BOOT, FIFO empty, outstanding=0, drop_cnt=0. Reset mid-transaction discards everything; late responses are not counted.
- FSM states:
  - BOOT: no request issued; unconditional transition to RUN on the next edge.
  - RUN: normal operation.
  - HALT: only reachable with the optional feature.
- Request issue in RUN: imem_req_valid = (fifo_count + outstanding < FIFO_DEPTH). Once asserted, imem_req_valid and imem_req_addr are held stable until accepted, unless a redirect arrives.
- On a handshake (valid&ready): PC += 4 and outstanding += 1. PC wraps modulo 2^ADDR_WIDTH.
- Response handling:
  - drop_cnt>0: the response is discarded and drop_cnt -= 1.
  - Otherwise: the word is pushed with its PC; the head becomes visible the following cycle (1-cycle rsp-to-instr_valid latency).
  - Either way, outstanding -= 1.
- Pop: the head leaves when instr_valid&instr_ready. Push and pop in the same cycle keep the count unchanged. A full FIFO cannot overflow because of the credit rule.
- Redirect (highest priority, same-cycle):
  - FIFO flushed; any same-cycle pop and push are ignored.
  - PC <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - drop_cnt <= outstanding + (request accepted this cycle) − (response arrived this cycle), with outstanding set to the same value.
  - instr_valid=0 on the next cycle.
  - A new request to the target may issue the following cycle, provided the credit rule allows it (drops count toward outstanding).
- Back-to-back redirects: the latest target wins; drop_cnt is recomputed each time.
- instr_pc of a redirected fetch equals the aligned target.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]≠0 flushes the FIFO as normal, sets fetch_misaligned=1 and moves the FSM to HALT.
  - In HALT: no requests issue, responses are still drained and discarded, and the unit leaves HALT only through reset.
- Undefined: low bits are silently masked; there is no HALT state and no port.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - PC_STEP=4.
  - NOP_INSTR=32'h0000_0013, used by benches and the downstream bubble insertion.
- Sub-module fetch_fifo: parameterised DEPTH×(DATA_WIDTH+ADDR_WIDTH) synchronous FIFO with flush, push, pop, count, head outputs.
- The PC, credit and drop logic stay in fetch_unit.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory latency, instr_ready=1 → cycle 1 BOOT (no request); requests issue at 0x0, 0x4, 0x8…; instr_pc sequence 0x0, 0x4, 0x8 with continuous instr_valid after fill.
- instr_ready=0 for 10 cycles → at most 2 requests outstanding, FIFO holds 0x0 and 0x4 words, no third request; releasing ready resumes without loss or duplication.
- Redirect to 0x100 with 2 responses in flight → both responses discarded; next instr_pc=0x100, then 0x104.
- Redirect coincident with response arrival and request acceptance → drop_cnt counts correctly; no stale instr_valid; first delivered instr_pc=target.
- imem_req_ready held low 5 cycles → imem_req_addr stable at 0x8; a redirect during the stall changes the address to the target on the next cycle.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 → fetch_misaligned=1, no further requests, instr_valid stays 0 until rst_n asserted. Without the macro → fetch resumes at 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {word, pc} pairs, with flush.
// Head outputs read zero while the buffer is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic [ADDR_WIDTH-1:0]   push_pc,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    head_valid,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [ADDR_WIDTH-1:0]   head_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic                  do_push, do_pop;

  // Flush dominates: a same-cycle push or pop is discarded.
  assign do_push    = push && !flush;
  assign do_pop     = pop && head_valid && !flush;
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? data_mem[rd_ptr] : '0;
  assign head_pc    = head_valid ? pc_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr] <= push_data;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, request credits, redirect flush/drop and instruction buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect trap and HALT state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misaligned
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, rsp_pc;
  logic [CW-1:0]         outstanding, out_next, drop_cnt, fifo_count;
  logic                  req_fire, rsp_take, rsp_keep, redir;

  // Valid/ready: a transfer happens on any rising edge where valid and ready are both high;
  // a raised request stays stable until accepted because only a handshake grows the credit sum.
  assign imem_req_valid = (state == RUN) &&
                          (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep       = rsp_take && (drop_cnt == '0);
  assign redir          = redirect_valid && (state != HALT);
  assign out_next       = outstanding + CW'(req_fire) - CW'(rsp_take);

  // Requests are sequential since the last redirect, so the oldest live one sits outstanding words back.
  assign rsp_pc = pc - (ADDR_WIDTH'(outstanding) << 2);

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      default: state_next = state;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redir && (redirect_pc[1:0] != 2'b00)) state_next = HALT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= out_next;
      if (redir) begin
        pc       <= redirect_pc & ~ADDR_WIDTH'(3);
        drop_cnt <= out_next;
      end else begin
        if (req_fire) pc <= pc + ADDR_WIDTH'(PC_STEP);
        if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       fetch_misaligned <= 1'b0;
    else if (redir && (redirect_pc[1:0] != 2'b00))    fetch_misaligned <= 1'b1;
  end
`endif

  fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redir),
    .push       (rsp_keep),
    .push_data  (imem_rsp_data),
    .push_pc    (rsp_pc),
    .pop        (instr_ready),
    .count      (fifo_count),
    .head_valid (instr_valid),
    .head_data  (instr),
    .head_pc    (instr_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven cycle vectors plus directed multi-cycle sequences.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int n_req = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];
  logic        mem_stall = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Instruction memory: 1-cycle latency, in order, responses held off while mem_stall is high.
  initial begin : mem_model
    logic        hs;
    logic [31:0] hs_addr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = NOP_INSTR;
    forever begin
      @(negedge clk);
      hs      = imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = NOP_INSTR;
      if (!rst_n) begin
        mem_q.delete();
      end else begin
        if (hs) begin
          mem_q.push_back(hs_addr);
          n_req++;
        end
        if (!mem_stall && mem_q.size() > 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_q.pop_front());
        end
      end
    end
  end

  // Scoreboard: every word decode accepts must match the next expected pc and its memory word.
  initial begin : consumer
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready && !redirect_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e);
        chk("instr", instr, mem_word(e));
      end
    end
  end

  task automatic do_reset();
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_stall      = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    n_req = 0;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misaligned", fetch_misaligned, 0);
`endif
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t row(bit rst, bit redir, logic [31:0] rpc, bit rv,
                               logic [31:0] a, bit iv, logic [31:0] p);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc;
    v.e_rv = rv; v.e_addr = a; v.e_iv = iv; v.e_ipc = p;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[18];
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Rows are sampled after successive edges; inputs of a row apply to the following edge.
    tbl[0]  = row(1, 0, 0, 0, 32'h00, 0, 0);
    tbl[1]  = row(0, 0, 0, 1, 32'h00, 0, 0);
    tbl[2]  = row(0, 0, 0, 1, 32'h04, 0, 0);
    tbl[3]  = row(0, 0, 0, 0, 32'h08, 1, 32'h00);
    tbl[4]  = row(0, 0, 0, 1, 32'h08, 1, 32'h04);
    tbl[5]  = row(0, 0, 0, 1, 32'h0C, 0, 0);
    tbl[6]  = row(0, 0, 0, 0, 32'h10, 1, 32'h08);
    tbl[7]  = row(0, 0, 0, 1, 32'h10, 1, 32'h0C);
    tbl[8]  = row(0, 0, 0, 1, 32'h14, 0, 0);
    // Redirect coinciding with acceptance of 0xC and the response for 0x8.
    tbl[9]  = row(1, 0, 0, 0, 32'h00, 0, 0);
    tbl[10] = row(0, 0, 0, 1, 32'h00, 0, 0);
    tbl[11] = row(0, 0, 0, 1, 32'h04, 0, 0);
    tbl[12] = row(0, 0, 0, 0, 32'h08, 1, 32'h00);
    tbl[13] = row(0, 0, 0, 1, 32'h08, 1, 32'h04);
    tbl[14] = row(0, 1, 32'h200, 1, 32'h0C, 0, 0);
    tbl[15] = row(0, 0, 0, 1, 32'h200, 0, 0);
    tbl[16] = row(0, 0, 0, 1, 32'h204, 0, 0);
    tbl[17] = row(0, 0, 0, 0, 32'h208, 1, 32'h200);

    for (int k = 0; k < 18; k++) begin
      if (tbl[k].rst) do_reset();
      chk($sformatf("req_valid[%0d]", k), imem_req_valid, tbl[k].e_rv);
      chk($sformatf("req_addr[%0d]", k), imem_req_addr, tbl[k].e_addr);
      chk($sformatf("instr_valid[%0d]", k), instr_valid, tbl[k].e_iv);
      if (tbl[k].e_iv) begin
        chk($sformatf("head_pc[%0d]", k), instr_pc, tbl[k].e_ipc);
        exp_q.push_back(tbl[k].e_ipc);
      end
      redirect_valid = tbl[k].redir;
      redirect_pc    = tbl[k].rpc;
      step();
    end
    redirect_valid = 1'b0;

    // Decode stalled: two requests then the credit limit holds.
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    chk("bp_req_count", n_req, 2);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_req_addr", imem_req_addr, 32'h08);
    chk("bp_instr_valid", instr_valid, 1);
    chk("bp_instr_pc", instr_pc, 32'h00);
    chk("bp_instr", instr, mem_word(32'h00));
    exp_q.push_back(32'h00); exp_q.push_back(32'h04);
    exp_q.push_back(32'h08); exp_q.push_back(32'h0C);
    instr_ready = 1'b1;
    repeat (12) step();

    // Redirect with two responses still in flight.
    do_reset();
    mem_stall = 1'b1;
    repeat (5) step();
    chk("inflight_req_valid", imem_req_valid, 0);
    chk("inflight_instr_valid", instr_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    mem_stall      = 1'b0;
    step();
    redirect_valid = 1'b0;
    chk("redir_instr_valid", instr_valid, 0);
    chk("redir_addr", imem_req_addr, 32'h100);
    chk("redir_credit_held", imem_req_valid, 0);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    repeat (15) step();

    // Memory not ready: request held stable, then redirected during the stall.
    do_reset();
    exp_q.push_back(32'h00); exp_q.push_back(32'h04);
    repeat (3) step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall_valid[%0d]", i), imem_req_valid, 1);
      chk($sformatf("stall_addr[%0d]", i), imem_req_addr, 32'h08);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk("stall_redir_valid", imem_req_valid, 1);
    chk("stall_redir_addr", imem_req_addr, 32'h300);
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    repeat (10) step();

    // Misaligned redirect target.
    do_reset();
    exp_q.push_back(32'h00); exp_q.push_back(32'h04);
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_flag", fetch_misaligned, 1);
    chk("trap_req_valid", imem_req_valid, 0);
    chk("trap_instr_valid", instr_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("halt_req_valid[%0d]", i), imem_req_valid, 0);
      chk($sformatf("halt_instr_valid[%0d]", i), instr_valid, 0);
    end
    chk("halt_flag", fetch_misaligned, 1);
`else
    chk("mask_addr", imem_req_addr, 32'h100);
    chk("mask_req_valid", imem_req_valid, 1);
    chk("mask_instr_valid", instr_valid, 0);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    repeat (10) step();
`endif

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
